// File: rtl/jt7759_rom_arb.sv
// Two-channel sample-ROM arbiter for dual JT7759 boards: one cached word per channel,
// round-robin on misses, channel index drives the ROM bank bit.
//
// state  | meaning
// IDLE   | no fetch in flight; grant a pending miss or keep rom_cs low
// SETTLE | address just issued; rom_ok may still refer to the old address
// WAIT   | waiting for rom_ok; data lands in the granted channel's cache
module jt7759_rom_arb #(
  parameter int AW = 17,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ch0_cs,
  input  logic [AW-1:0] ch0_addr,
  input  logic          ch0_flush,
  output logic [DW-1:0] ch0_data,
  output logic          ch0_ok,
  input  logic          ch1_cs,
  input  logic [AW-1:0] ch1_addr,
  input  logic          ch1_flush,
  output logic [DW-1:0] ch1_data,
  output logic          ch1_ok,
  output logic          rom_cs,
  output logic [AW:0]   rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ok
);

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT} state_t;

  state_t              state;
  logic                rr;
  logic                gnt;
  logic                discard;
  logic [1:0]          valid;
  logic [1:0][AW-1:0]  tag;
  logic [1:0][DW-1:0]  data;
  logic [1:0]          ok;

  logic [1:0]          cs;
  logic [1:0]          flush;
  logic [1:0][AW-1:0]  ch_addr;
  logic [1:0]          hit;
  logic [1:0]          pend;
  logic                gsel;
  logic                fill;

  assign cs      = {ch1_cs, ch0_cs};
  assign flush   = {ch1_flush, ch0_flush};
  assign ch_addr = {ch1_addr, ch0_addr};

  always_comb begin
    hit = '0;
    for (int n = 0; n < 2; n++)
      hit[n] = valid[n] && (tag[n] == ch_addr[n]);
  end

  assign pend = cs & ~hit;
  assign gsel = (pend[0] && pend[1]) ? rr : pend[1];
  // A flush arriving on the very edge the data returns still wins over the fill
  assign fill = (state == WAIT) && rom_ok && !discard && !flush[gnt];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= '0;
      tag   <= '0;
      data  <= '0;
      ok    <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        ok[n] <= cs[n] && hit[n];
        if (flush[n]) begin
          valid[n] <= 1'b0;
        end else if (fill && (gnt == n[0])) begin
          valid[n] <= 1'b1;
          tag[n]   <= rom_addr[AW-1:0];
          data[n]  <= rom_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      rr       <= 1'b0;
      gnt      <= 1'b0;
      discard  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|pend) begin
            rom_addr <= {gsel, ch_addr[gsel]};
            rom_cs   <= 1'b1;
            gnt      <= gsel;
            rr       <= ~gsel;
            discard  <= 1'b0;
            state    <= SETTLE;
          end else begin
            rom_cs <= 1'b0;
          end
        end
        SETTLE: begin
          if (flush[gnt]) discard <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (flush[gnt]) discard <= 1'b1;
          if (rom_ok) begin
            rom_cs <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ch0_data = data[0];
  assign ch1_data = data[1];
  assign ch0_ok   = ok[0];
  assign ch1_ok   = ok[1];

endmodule
